// File: rtl/gmii_rx_axis_packer.sv
// gmii_rx_axis_packer
//
// Packs the GMII receive byte stream (8 bits per clk) into DATA_W-bit
// AXI-Stream beats and buffers them in a first-word fall-through FIFO.
// Everything runs in the GMII receive clock domain, ahead of any CDC stage.
//
// Ports
//   clk, rst_n         GMII receive clock, async active-low reset
//   gmii_rx_dv/rxd/er  GMII receive byte interface
//   axis_t*            AXI-Stream master (tdata little-endian, tuser=frame
//                      error, meaningful with tlast=1)
//   frame_cnt          frames closed into the FIFO (saturating)
//   drop_cnt           frames truncated by FIFO overflow (saturating)
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | between frames; a new frame starts only once dv=0 has been seen
// PRE       | skipping preamble until SFD 0xD5
// DATA      | packing payload bytes into the accumulator
// DISCARD   | overflow hit; drop bytes until dv falls
// FLUSH_ERR | push one error beat (tkeep=1, tlast=1, tuser=1) once not full

module gmii_rx_axis_packer #(
  parameter int DATA_W         = 64,
  parameter int FIFO_DEPTH     = 16,
  parameter int STRIP_PREAMBLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                gmii_rx_dv,
  input  logic [7:0]          gmii_rxd,
  input  logic                gmii_rx_er,
  output logic                axis_tvalid,
  output logic [DATA_W-1:0]   axis_tdata,
  output logic [DATA_W/8-1:0] axis_tkeep,
  output logic                axis_tlast,
  output logic                axis_tuser,
  input  logic                axis_tready,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         drop_cnt
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(KEEP_W + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int ENT_W  = DATA_W + KEEP_W + 2;

  localparam logic [CNT_W-1:0] ACC_FULL  = CNT_W'(KEEP_W);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_DISCARD,
    S_FLUSH_ERR
  } state_t;

  state_t state, state_next;

  // acc_cnt == ACC_FULL means the accumulator is holding a completed beat
  // for one cycle, waiting to learn from dv whether it is the last one.
  logic [DATA_W-1:0] acc_data, acc_next;
  logic [CNT_W-1:0]  acc_cnt, cnt_next;
  logic              err_flag, err_next;
  // Set once dv=0 has been observed in IDLE; guards against joining a frame
  // mid-stream after reset or after an overflow flush.
  logic              armed, armed_next;

  logic              push_req;
  logic [DATA_W-1:0] push_data;
  logic [KEEP_W-1:0] push_keep;
  logic              push_last;
  logic              push_user;
  logic              push_ok;
  logic              drop_evt;
  logic [KEEP_W-1:0] cnt_keep;

  logic [ENT_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    fifo_count;
  logic              fifo_full;
  logic              pop;
  logic [ENT_W-1:0]  fifo_rd;

  // Low acc_cnt ones; wraps to all ones when the accumulator is full.
  assign cnt_keep = (KEEP_W'(1) << acc_cnt) - KEEP_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      acc_data <= '0;
      acc_cnt  <= '0;
      err_flag <= 1'b0;
      armed    <= 1'b0;
    end else begin
      state    <= state_next;
      acc_data <= acc_next;
      acc_cnt  <= cnt_next;
      err_flag <= err_next;
      armed    <= armed_next;
    end
  end

  always_comb begin
    state_next = state;
    acc_next   = acc_data;
    cnt_next   = acc_cnt;
    err_next   = err_flag;
    armed_next = armed;
    push_req   = 1'b0;
    push_data  = acc_data;
    push_keep  = cnt_keep;
    push_last  = 1'b0;
    push_user  = 1'b0;
    drop_evt   = 1'b0;

    unique case (state)
      S_IDLE: begin
        err_next = 1'b0;
        acc_next = '0;
        cnt_next = '0;
        if (!gmii_rx_dv) begin
          armed_next = 1'b1;
        end else if (armed) begin
          if (STRIP_PREAMBLE != 0) begin
            state_next = S_PRE;
          end else begin
            state_next = S_DATA;
            acc_next   = {{(DATA_W-8){1'b0}}, gmii_rxd};
            cnt_next   = CNT_W'(1);
            err_next   = gmii_rx_er;
          end
        end
      end

      S_PRE: begin
        if (!gmii_rx_dv) begin
          state_next = S_IDLE;
          armed_next = 1'b1;
        end else begin
          err_next = err_flag | gmii_rx_er;
          if (gmii_rxd == 8'hD5) state_next = S_DATA;
        end
      end

      S_DATA: begin
        if (acc_cnt == ACC_FULL) begin
          // Staged beat goes out now; dv tells us whether it closes the frame.
          push_req  = 1'b1;
          push_keep = '1;
          push_last = ~gmii_rx_dv;
          push_user = ~gmii_rx_dv & err_flag;
          if (gmii_rx_dv) begin
            acc_next = {{(DATA_W-8){1'b0}}, gmii_rxd};
            cnt_next = CNT_W'(1);
          end else begin
            acc_next = '0;
            cnt_next = '0;
          end
        end else if (gmii_rx_dv) begin
          for (int i = 0; i < KEEP_W; i++) begin
            if (acc_cnt == CNT_W'(i)) acc_next[8*i +: 8] = gmii_rxd;
          end
          cnt_next = acc_cnt + CNT_W'(1);
        end else begin
          // Partial final beat; a zero-byte frame writes nothing.
          if (acc_cnt != '0) begin
            push_req  = 1'b1;
            push_last = 1'b1;
            push_user = err_flag;
          end
          acc_next = '0;
          cnt_next = '0;
        end

        if (gmii_rx_dv) begin
          err_next = err_flag | gmii_rx_er;
        end else begin
          state_next = S_IDLE;
          armed_next = 1'b1;
        end

        if (push_req && fifo_full) begin
          drop_evt   = 1'b1;
          state_next = S_DISCARD;
          acc_next   = '0;
          cnt_next   = '0;
        end
      end

      S_DISCARD: begin
        acc_next = '0;
        cnt_next = '0;
        if (!gmii_rx_dv) state_next = S_FLUSH_ERR;
      end

      S_FLUSH_ERR: begin
        push_req  = 1'b1;
        push_data = '0;
        push_keep = KEEP_W'(1);
        push_last = 1'b1;
        push_user = 1'b1;
        if (!fifo_full) begin
          state_next = S_IDLE;
          armed_next = 1'b0;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  // Beat FIFO: first-word fall-through, registered occupancy. A full FIFO
  // refuses a write even when a pop happens in the same cycle.
  assign fifo_full = (fifo_count == FIFO_FULL);
  assign push_ok   = push_req & ~fifo_full;
  assign pop       = axis_tvalid & axis_tready;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {push_user, push_last, push_keep, push_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Outputs are forced to zero while empty so the storage array needs no reset.
  assign fifo_rd     = mem[rd_ptr];
  assign axis_tvalid = (fifo_count != '0);
  assign axis_tdata  = axis_tvalid ? fifo_rd[DATA_W-1:0] : '0;
  assign axis_tkeep  = axis_tvalid ? fifo_rd[DATA_W +: KEEP_W] : '0;
  assign axis_tlast  = axis_tvalid & fifo_rd[ENT_W-2];
  assign axis_tuser  = axis_tvalid & fifo_rd[ENT_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (push_ok && push_last && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
      if (drop_evt && drop_cnt != 16'hFFFF)              drop_cnt  <= drop_cnt + 16'd1;
    end
  end

endmodule
